// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake and data bundle for the execute-issue stage.
//   ID side   : inValid/inReady, aluOp, funct, rsData, rtData, immExt, aluSrc,
//               fwdA, fwdB, exMemResult, memWbResult, flush
//   ALU side  : outValid/outReady, aluSel, in1, in2, storeData, illegal
// slave  = the issue stage itself; master = whoever drives it (ID/hazard/ALU).
interface alu_issue_if #(parameter int WIDTH = 32);
  logic             inValid;
  logic             inReady;
  logic [1:0]       aluOp;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] rtData;
  logic [WIDTH-1:0] immExt;
  logic             aluSrc;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic [WIDTH-1:0] exMemResult;
  logic [WIDTH-1:0] memWbResult;
  logic             flush;
  logic             outReady;
  logic             outValid;
  logic [3:0]       aluSel;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] storeData;
  logic             illegal;

  modport slave (
    input  inValid, aluOp, funct, rsData, rtData, immExt, aluSrc,
           fwdA, fwdB, exMemResult, memWbResult, flush, outReady,
    output inReady, outValid, aluSel, in1, in2, storeData, illegal
  );

  modport master (
    output inValid, aluOp, funct, rsData, rtData, immExt, aluSrc,
           fwdA, fwdB, exMemResult, memWbResult, flush, outReady,
    input  inReady, outValid, aluSel, in1, in2, storeData, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: execute-issue stage in front of the 32-bit ALU.
//   Resolves operand forwarding and the immediate select, decodes
//   aluOp/funct into the ALU's 4-bit select, and holds everything in one
//   registered slot with a valid/ready handshake.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous, active-high reset
//   io_bus - alu_issue_if.slave (see interface file for signal list)
module alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  io_bus
);

  logic             r_outValid;
  logic [3:0]       r_aluSel;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_in2;
  logic [WIDTH-1:0] r_storeData;
  logic             r_illegal;

  logic [3:0]       w_sel;
  logic             w_ill;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_fwdB;
  logic             w_inReady;
  logic             w_load;

  // ALU operation decode
  always_comb begin
    w_sel = 4'd2;
    w_ill = 1'b0;
    unique case (io_bus.aluOp)
      2'b00: w_sel = 4'd2;
      2'b01: w_sel = 4'd6;
      2'b11: w_sel = 4'd1;
      default: begin
        unique case (io_bus.funct)
          6'h20: w_sel = 4'd2;
          6'h22: w_sel = 4'd6;
          6'h24: w_sel = 4'd0;
          6'h25: w_sel = 4'd1;
          6'h2A: w_sel = 4'd7;
          6'h27: w_sel = 4'd12;
          default: begin
            w_sel = 4'd15;  // ALU returns 0 for this select
            w_ill = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Forward select 11 is reserved and falls back to the register file.
  always_comb begin
    unique case (io_bus.fwdA)
      2'b01:   w_opA = io_bus.memWbResult;
      2'b10:   w_opA = io_bus.exMemResult;
      default: w_opA = io_bus.rsData;
    endcase
    unique case (io_bus.fwdB)
      2'b01:   w_fwdB = io_bus.memWbResult;
      2'b10:   w_fwdB = io_bus.exMemResult;
      default: w_fwdB = io_bus.rtData;
    endcase
  end

  // rst term keeps inReady high while the slot register is still settling.
  assign w_inReady = rst || !r_outValid || io_bus.outReady;
  assign w_load    = io_bus.inValid && w_inReady && !io_bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid  <= 1'b0;
      r_aluSel    <= '0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_storeData <= '0;
      r_illegal   <= 1'b0;
    end else if (io_bus.flush) begin
      // Data registers keep their contents; only the valid/illegal flags die.
      r_outValid <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_load) begin
      r_outValid  <= 1'b1;
      r_aluSel    <= w_sel;
      r_in1       <= w_opA;
      r_in2       <= io_bus.aluSrc ? io_bus.immExt : w_fwdB;
      r_storeData <= w_fwdB;
      r_illegal   <= w_ill;
    end else if (r_outValid && io_bus.outReady) begin
      r_outValid <= 1'b0;
    end
  end

  assign io_bus.inReady   = w_inReady;
  assign io_bus.outValid  = r_outValid;
  assign io_bus.aluSel    = r_aluSel;
  assign io_bus.in1       = r_in1;
  assign io_bus.in2       = r_in2;
  assign io_bus.storeData = r_storeData;
  assign io_bus.illegal   = r_illegal;

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-issue stage sitting directly upstream of the 32-bit ALU. Each cycle it accepts one decoded instruction from the ID stage. It resolves operand forwarding and the immediate select, and translates the ALUOp/funct pair into the ALU's 4-bit operation select. It holds the result in a registered ID/EX slot with a valid/ready handshake, so the ALU always sees stable `in1`/`in2`/`aluSel` for a whole cycle.

## Interface
Parameters:
- `WIDTH`, 32, datapath width of operands and forwarded results.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `inValid`  in  1  ID stage presents an instruction.
- `inReady`  out  1  stage can accept this cycle.
- `aluOp`  in  2  main-decoder ALU class.
- `funct`  in  6  R-type function field.
- `rsData`, `rtData`  in  WIDTH  register-file read data.
- `immExt`  in  WIDTH  sign/zero-extended immediate.
- `aluSrc`  in  1  1 = operand B is `immExt`.
- `fwdA`, `fwdB`  in  2  forward select: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 reserved (treated as 00).
- `exMemResult`, `memWbResult`  in  WIDTH  forwarding sources.
- `flush`  in  1  kill the slot (branch taken / exception).
- `outReady`  in  1  downstream (ALU → EX/MEM) accepts.
- `outValid`  out  1  slot holds a live instruction.
- `aluSel`  out  4  operation select to ALU.
- `in1`, `in2`  out  WIDTH  ALU operands.
- `storeData`  out  WIDTH  forwarded rt value (for stores), independent of `aluSrc`.
- `illegal`  out  1  registered: R-type funct not recognised.

## Operation
- Decode (combinational on inputs, registered into `aluSel`):
  - `aluOp` 00 → 2 (add).
  - `aluOp` 01 → 6 (sub).
  - `aluOp` 11 → 1 (or).
  - `aluOp` 10 decodes `funct`:
    - 0x20 → 2.
    - 0x22 → 6.
    - 0x24 → 0.
    - 0x25 → 1.
    - 0x2A → 7.
    - 0x27 → 12.
    - Any other value → `aluSel` 15 and `illegal` 1. The ALU yields 0 for 15; the slot still goes valid.
- Operand A = mux(`fwdA`: `rsData`/`memWbResult`/`exMemResult`).
- Forwarded B = mux(`fwdB`: `rtData`/`memWbResult`/`exMemResult`).
- `in2` = `aluSrc` ? `immExt` : forwarded B.
- `storeData` = forwarded B.
- Handshake:
  - `inReady = !outValid || outReady` (combinational; no dependency on `inValid`).
  - load = `inValid && inReady && !flush`.
  - On load: all data outputs are captured and `outValid` goes to 1.
  - Else if `outValid && outReady`: `outValid` goes to 0 and data outputs hold their last value.
  - Else: the slot holds unchanged (stall).
- Flush has priority over everything except reset. On `flush`, `outValid` goes to 0 and `illegal` goes to 0 next edge, and the input on that cycle is discarded even if `inValid` is high.
- Reset has priority over flush and load. All outputs read 0 after the reset edge:
  - `outValid` = 0, `aluSel` = 0, `in1` = `in2` = 0, `storeData` = 0, `illegal` = 0.
  - `inReady` reads 1 during and after reset.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Throughput 1 instruction/cycle when `outReady` is held high.
- Simultaneous drain and fill (`outValid`, `outReady`, `inValid` all 1): new instruction captured, `outValid` stays 1, no bubble.
- Stall (`outValid` = 1, `outReady` = 0): `inReady` = 0 and outputs are bit-stable until accepted.
- Forwarding sources are sampled only on the load edge. Changes during a stall do not affect held operands; the hazard unit must re-present the instruction if needed.
- Reset in mid-stall drops the held instruction with no further `outValid`.

## Test plan
- Reset: assert `rst` 2 cycles with `inValid` = 1 → all outputs 0, `outValid` = 0, `inReady` = 1; the first load lands exactly 1 cycle after `rst` drops.
- R-type decode: stream `funct` 0x20, 0x22, 0x24, 0x25, 0x2A, 0x27, 0x3F with `aluOp` = 10, `outReady` = 1:
  - `aluSel` = 2, 6, 0, 1, 7, 12, 15 on consecutive cycles.
  - `illegal` = 1 only on the last.
- Forwarding: `rsData` = 0x11, `memWbResult` = 0x22, `exMemResult` = 0x33, `fwdA` = 10, `fwdB` = 01, `aluSrc` = 1, `immExt` = 0xFFFF_FFFC → `in1` = 0x33, `in2` = 0xFFFF_FFFC, `storeData` = 0x22.
- Stall: load A, hold `outReady` = 0 for 3 cycles while changing all inputs → `inReady` = 0 and outputs equal A throughout. Raise `outReady` with B presented → B captured next edge, no bubble.
- Flush: `inValid` = 1, `flush` = 1 with slot valid and `outReady` = 0 → next cycle `outValid` = 0, input discarded. Following cycle loads normally.
- `aluOp` 00/01/11 with `funct` = 0x3F → `aluSel` = 2/6/1, `illegal` = 0.
